// File: rtl/case_4_mul_share_sched_pkg.sv
// Shared definitions for the shared-multiplier scheduler.
// Holds the default widths, the arb_mode encodings and a clog2 helper
// used to size requester ids.
package case_4_pkg;

  // Ceiling log2. Used to size requester id fields.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned A_W_DEF  = 14;
  localparam int unsigned B_W_DEF  = 12;
  localparam int unsigned P_W_DEF  = 26;
  localparam int unsigned ID_W_DEF = clog2(NREQ_DEF);

  // arb_mode encodings
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/case_4_mul_share_sched_if.sv
// Requester/response bus of the shared-multiplier scheduler.
//   req_valid/req_ready : per-requester operand handshake
//   req_a/req_b         : packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_p        : requester index and signed product
// master = requesters plus result consumer; slave = scheduler.
interface case_4_mul_share_sched_if
  import case_4_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned A_W  = A_W_DEF,
  parameter int unsigned B_W  = B_W_DEF,
  parameter int unsigned P_W  = P_W_DEF,
  parameter int unsigned ID_W = clog2(NREQ)
);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [P_W-1:0]      rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/case_4_mul_share_sched_arb.sv
// Combinational requester arbiter.
//   req   : request vector
//   ptr   : round-robin search start index
//   mode  : ARB_RR searches from ptr with wrap, ARB_FIXED searches from 0
//   grant : one-hot grant (all zero when no request)
//   idx   : encoded index of the granted requester
//   any   : at least one request present
module case_4_rr_arb
  import case_4_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            mode,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int unsigned     base;
  int unsigned     s;
  logic [ID_W-1:0] j;

  // First requesting index at or after base, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = 0;
    j     = '0;
    base  = (mode == ARB_RR) ? 32'(ptr) : 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      s = base + k;
      if (s >= NREQ) s = s - NREQ;
      j = ID_W'(s);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/case_4_mul_share_sched.sv
// Round-robin / fixed-priority scheduler time-sharing one signed multiplier
// among NREQ requesters. Two-stage pipeline: S1 holds the granted operands,
// S2 holds the product and drives the response port.
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   arb_mode       : 1 = round-robin, 0 = fixed priority (index 0 highest)
//   bus            : requester operand ports and tagged response port
//   busy           : an op is held in S1 or S2
//   done_cnt       : completed response handshakes, wraps at 2^32
module case_4_mul_share_sched
  import case_4_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned A_W  = A_W_DEF,
  parameter int unsigned B_W  = B_W_DEF,
  parameter int unsigned P_W  = P_W_DEF,
  parameter int unsigned ID_W = clog2(NREQ)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     arb_mode,
  case_4_mul_share_sched_if.slave  bus,
  output logic                     busy,
  output logic [31:0]              done_cnt
);

  localparam int unsigned FW = A_W + B_W;

  logic                   v1;
  logic                   v2;
  logic [ID_W-1:0]        id1;
  logic [ID_W-1:0]        id2;
  logic signed [A_W-1:0]  a1;
  logic signed [B_W-1:0]  b1;
  logic [P_W-1:0]         p2;
  logic [ID_W-1:0]        ptr;

  logic                   adv1;
  logic                   adv2;
  logic                   accept;
  logic                   any;
  logic [NREQ-1:0]        grant;
  logic [ID_W-1:0]        gidx;
  logic signed [A_W-1:0]  a_sel;
  logic signed [B_W-1:0]  b_sel;
  logic signed [FW-1:0]   a_ext;
  logic signed [FW-1:0]   b_ext;
  logic signed [FW-1:0]   prod;

  // Pipeline advance: a stage may load when it is empty or drains this cycle.
  always_comb begin
    adv2   = !v2 || bus.rsp_ready;
    adv1   = !v1 || adv2;
    accept = adv1 && any;
  end

  case_4_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .mode  (arb_mode),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  // Operand select for the granted requester.
  assign a_sel = bus.req_a[32'(gidx)*A_W +: A_W];
  assign b_sel = bus.req_b[32'(gidx)*B_W +: B_W];

  // The single shared multiply, full precision then truncated to P_W.
  assign a_ext = FW'(a1);
  assign b_ext = FW'(b1);
  assign prod  = a_ext * b_ext;

  assign bus.req_ready = adv1 ? grant : '0;
  assign bus.rsp_valid = v2;
  assign bus.rsp_id    = id2;
  assign bus.rsp_p     = p2;
  assign busy          = v1 || v2;

  // Pipeline registers, RR pointer and completion counter.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      id1      <= '0;
      id2      <= '0;
      a1       <= '0;
      b1       <= '0;
      p2       <= '0;
      ptr      <= '0;
      done_cnt <= '0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          id2 <= id1;
          p2  <= P_W'(prod);
        end
      end
      if (adv1) begin
        v1 <= any;
        if (any) begin
          id1 <= gidx;
          a1  <= a_sel;
          b1  <= b_sel;
        end
      end
      // Pointer only moves on an accepted round-robin grant.
      if (accept && (arb_mode == ARB_RR)) begin
        if (gidx == ID_W'(NREQ - 1)) ptr <= '0;
        else                          ptr <= gidx + ID_W'(1);
      end
      if (v2 && bus.rsp_ready) done_cnt <= done_cnt + 32'd1;
    end
  end

endmodule
